// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module     : cpu_types_pkg
// Description: Shared CPU-side types for the coherent dcache bus agent.
//              bus_op_t encodes the block-level bus operations the dcache can
//              request; the helpers compute the two word addresses of a block.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    OP_FILL_S = 2'd0,  // read block, shared intent
    OP_FILL_M = 2'd1,  // read block, write intent
    OP_WB     = 2'd2,  // write dirty block back
    OP_UPG    = 2'd3   // S->M upgrade, no data movement
  } bus_op_t;

  localparam int BLOCK_WORDS = 2;

  // Block base: clear the byte-offset bits of the address.
  function automatic logic [31:0] word0_addr(input logic [31:0] addr,
                                             input int unsigned off_bits);
    return addr & ~((32'd1 << off_bits) - 32'd1);
  endfunction

  // Last word of the block (second word for a 2-word block).
  function automatic logic [31:0] word1_addr(input logic [31:0] addr,
                                             input int unsigned off_bits);
    return word0_addr(addr, off_bits) + 32'(4 * (BLOCK_WORDS - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/coherent_dcache_bus_agent.sv
//------------------------------------------------------------------------------
// Module     : coherent_dcache_bus_agent
// Description: Cache-side coherence bus agent. Turns local block requests
//              (fill / writeback / upgrade) into dREN/dWEN/cctrans/ccwrite
//              sequences and answers controller snoops, supplying dirty data
//              and pulsing invalidate / downgrade to the tag array.
// Ports      : CLK, nRST            - clock, async active-low reset
//              req_*                - local request (held until req_done)
//              req_done, fill_data* - completion pulse and captured fill words
//              snp_addr, snp_hit/dirty/data*, snp_inv/clean - snoop tag side
//              dREN/dWEN/daddr/dstore/dload/dwait - controller data port
//              ccwait/ccinv/ccsnoopaddr/cctrans/ccwrite - coherence signals
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module coherent_dcache_bus_agent
  import cpu_types_pkg::*;
#(
  parameter int BLOCK_OFFSET_BITS = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  bus_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic        req_done,
  output logic [31:0] fill_data0,
  output logic [31:0] fill_data1,
  output logic [31:0] snp_addr,
  input  logic        snp_hit,
  input  logic        snp_dirty,
  input  logic [31:0] snp_data0,
  input  logic [31:0] snp_data1,
  output logic        snp_inv,
  output logic        snp_clean,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        cctrans,
  output logic        ccwrite
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FILL0    = 4'd1;
  localparam logic [3:0] S_FILL1    = 4'd2;
  localparam logic [3:0] S_WB0      = 4'd3;
  localparam logic [3:0] S_WB1      = 4'd4;
  localparam logic [3:0] S_UPG      = 4'd5;
  localparam logic [3:0] S_SNP_LOOK = 4'd6;
  localparam logic [3:0] S_SNP_RESP = 4'd7;
  localparam logic [3:0] S_SNP_WB0  = 4'd8;
  localparam logic [3:0] S_SNP_WB1  = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  logic [3:0]  state_q,     state_d;
  bus_op_t     op_q,        op_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata0_q,    wdata0_d;
  logic [31:0] wdata1_q,    wdata1_d;
  logic [31:0] fill0_q,     fill0_d;
  logic [31:0] fill1_q,     fill1_d;
  logic [31:0] snp_addr_q,  snp_addr_d;
  logic [31:0] sdata0_q,    sdata0_d;
  logic [31:0] sdata1_q,    sdata1_d;
  logic        inv_flag_q,  inv_flag_d;   // sticky ccinv seen during this snoop
  logic        dirty_q,     dirty_d;      // this snoop is supplying a dirty block
  logic        wb_done_q,   wb_done_d;    // both snoop words have been accepted
  logic        snp_inv_q,   snp_inv_d;
  logic        snp_clean_q, snp_clean_d;

  logic w_inv_seen;
  assign w_inv_seen = inv_flag_q | ccinv;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata0_d    = wdata0_q;
    wdata1_d    = wdata1_q;
    fill0_d     = fill0_q;
    fill1_d     = fill1_q;
    snp_addr_d  = snp_addr_q;
    sdata0_d    = sdata0_q;
    sdata1_d    = sdata1_q;
    inv_flag_d  = inv_flag_q;
    dirty_d     = dirty_q;
    wb_done_d   = wb_done_q;
    snp_inv_d   = 1'b0;
    snp_clean_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Snoops win so the controller is never blocked behind a local miss.
        if (ccwait) begin
          snp_addr_d = ccsnoopaddr;
          inv_flag_d = 1'b0;
          dirty_d    = 1'b0;
          wb_done_d  = 1'b0;
          state_d    = S_SNP_LOOK;
        end else if (req_valid) begin
          op_d     = req_op;
          addr_d   = req_addr;
          wdata0_d = req_wdata0;
          wdata1_d = req_wdata1;
          case (req_op)
            OP_WB:   state_d = S_WB0;
            OP_UPG:  state_d = S_UPG;
            default: state_d = S_FILL0;
          endcase
        end
      end
      S_FILL0: if (!dwait) begin fill0_d = dload; state_d = S_FILL1; end
      S_FILL1: if (!dwait) begin fill1_d = dload; state_d = S_DONE;  end
      S_WB0:   if (!dwait) state_d = S_WB1;
      S_WB1:   if (!dwait) state_d = S_DONE;
      S_UPG:   if (!dwait) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_SNP_LOOK: begin
        inv_flag_d = w_inv_seen;
        state_d    = ccwait ? S_SNP_RESP : S_IDLE;
      end
      S_SNP_RESP: begin
        inv_flag_d = w_inv_seen;
        if (snp_hit && snp_dirty) begin
          sdata0_d = snp_data0;
          sdata1_d = snp_data1;
          dirty_d  = 1'b1;
          state_d  = S_SNP_WB0;
        end else if (!ccwait) begin
          snp_inv_d = w_inv_seen & snp_hit;
          state_d   = S_IDLE;
        end
      end
      S_SNP_WB0: begin
        inv_flag_d = w_inv_seen;
        if (!dwait) state_d = S_SNP_WB1;
      end
      S_SNP_WB1: begin
        inv_flag_d = w_inv_seen;
        if (!wb_done_q) begin
          if (!dwait) wb_done_d = 1'b1;
        end else if (!ccwait) begin
          // Invalidate takes precedence; otherwise the supplied line drops to S.
          snp_inv_d   = w_inv_seen & snp_hit;
          snp_clean_d = ~(w_inv_seen & snp_hit) & dirty_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FILL_S;
      addr_q      <= '0;
      wdata0_q    <= '0;
      wdata1_q    <= '0;
      fill0_q     <= '0;
      fill1_q     <= '0;
      snp_addr_q  <= '0;
      sdata0_q    <= '0;
      sdata1_q    <= '0;
      inv_flag_q  <= 1'b0;
      dirty_q     <= 1'b0;
      wb_done_q   <= 1'b0;
      snp_inv_q   <= 1'b0;
      snp_clean_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata0_q    <= wdata0_d;
      wdata1_q    <= wdata1_d;
      fill0_q     <= fill0_d;
      fill1_q     <= fill1_d;
      snp_addr_q  <= snp_addr_d;
      sdata0_q    <= sdata0_d;
      sdata1_q    <= sdata1_d;
      inv_flag_q  <= inv_flag_d;
      dirty_q     <= dirty_d;
      wb_done_q   <= wb_done_d;
      snp_inv_q   <= snp_inv_d;
      snp_clean_q <= snp_clean_d;
    end
  end

  logic [31:0] w_req_word0, w_req_word1, w_snp_word0, w_snp_word1;
  assign w_req_word0 = word0_addr(addr_q, BLOCK_OFFSET_BITS);
  assign w_req_word1 = word1_addr(addr_q, BLOCK_OFFSET_BITS);
  assign w_snp_word0 = word0_addr(snp_addr_q, BLOCK_OFFSET_BITS);
  assign w_snp_word1 = word1_addr(snp_addr_q, BLOCK_OFFSET_BITS);

  // Bus outputs are decoded purely from state so a reset clears them at once.
  always_comb begin
    req_done = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    daddr    = '0;
    dstore   = '0;
    case (state_q)
      S_FILL0: begin
        dREN = 1'b1; cctrans = 1'b1; ccwrite = (op_q == OP_FILL_M); daddr = w_req_word0;
      end
      S_FILL1: begin
        dREN = 1'b1; cctrans = 1'b1; ccwrite = (op_q == OP_FILL_M); daddr = w_req_word1;
      end
      S_WB0: begin dWEN = 1'b1; daddr = w_req_word0; dstore = wdata0_q; end
      S_WB1: begin dWEN = 1'b1; daddr = w_req_word1; dstore = wdata1_q; end
      S_UPG: begin cctrans = 1'b1; ccwrite = 1'b1; end
      S_DONE: req_done = 1'b1;
      S_SNP_RESP: begin cctrans = 1'b1; ccwrite = snp_hit & snp_dirty; end
      S_SNP_WB0: begin
        dWEN = 1'b1; cctrans = 1'b1; ccwrite = 1'b1; daddr = w_snp_word0; dstore = sdata0_q;
      end
      S_SNP_WB1: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        if (!wb_done_q) begin
          dWEN = 1'b1; daddr = w_snp_word1; dstore = sdata1_q;
        end
      end
      default: ;
    endcase
  end

  assign fill_data0 = fill0_q;
  assign fill_data1 = fill1_q;
  assign snp_addr   = snp_addr_q;
  assign snp_inv    = snp_inv_q;
  assign snp_clean  = snp_clean_q;

endmodule

`default_nettype wire

// File: tb/tb_coherent_dcache_bus_agent.sv
//------------------------------------------------------------------------------
// Module     : tb_coherent_dcache_bus_agent
// Description: Self-checking bench for coherent_dcache_bus_agent. A word-
//              addressed memory model tracks what fills must return and what
//              writebacks / snoop supplies leave behind.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_coherent_dcache_bus_agent;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid;
  bus_op_t     req_op;
  logic [31:0] req_addr, req_wdata0, req_wdata1;
  logic        req_done;
  logic [31:0] fill_data0, fill_data1, snp_addr;
  logic        snp_hit, snp_dirty;
  logic [31:0] snp_data0, snp_data1;
  logic        snp_inv, snp_clean, dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;
  logic        cctrans, ccwrite;

  coherent_dcache_bus_agent #(.BLOCK_OFFSET_BITS(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_done(req_done),
    .fill_data0(fill_data0), .fill_data1(fill_data1),
    .snp_addr(snp_addr), .snp_hit(snp_hit), .snp_dirty(snp_dirty),
    .snp_data0(snp_data0), .snp_data1(snp_data1),
    .snp_inv(snp_inv), .snp_clean(snp_clean),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .cctrans(cctrans), .ccwrite(ccwrite)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hDEAD, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic ren, input logic wen,
                         input logic cct, input logic ccw, input logic chk_addr,
                         input logic [31:0] addr, input logic [31:0] st);
    chk({tag, ".dREN"}, 32'(dREN), 32'(ren));
    chk({tag, ".dWEN"}, 32'(dWEN), 32'(wen));
    chk({tag, ".cctrans"}, 32'(cctrans), 32'(cct));
    chk({tag, ".ccwrite"}, 32'(ccwrite), 32'(ccw));
    if (chk_addr) chk({tag, ".daddr"}, daddr, addr);
    if (wen) chk({tag, ".dstore"}, dstore, st);
  endtask

  // Local request: one beat per block word (one for upgrade), 'stall' wait
  // cycles before each beat is accepted, then a single req_done cycle.
  task automatic do_req(input bus_op_t op, input logic [31:0] addr,
                        input logic [31:0] w0, input logic [31:0] w1, input int stall);
    logic [31:0] base, wa;
    int nb;
    bit is_fill;
    base    = addr & ~32'h7;
    nb      = (op == OP_UPG) ? 1 : 2;
    is_fill = (op == OP_FILL_S) || (op == OP_FILL_M);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_wdata0 = w0; req_wdata1 = w1; dwait = 1'b1;
    tick();
    for (int k = 0; k < nb; k++) begin
      wa = base + 32'(4 * k);
      for (int s = 0; s <= stall; s++) begin
        chk_bus($sformatf("req op%0d beat%0d", op, k), is_fill, op == OP_WB,
                op != OP_WB, (op == OP_FILL_M) || (op == OP_UPG), op != OP_UPG,
                wa, (k == 0) ? w0 : w1);
        chk("req_done_early", 32'(req_done), 32'd0);
        dwait = (s < stall);
        dload = (s < stall) ? $urandom : mem_rd(wa);
        tick();
      end
      if (op == OP_WB) mem[wa] = (k == 0) ? w0 : w1;
    end
    chk("req_done_pulse", 32'(req_done), 32'd1);
    chk_bus("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    if (is_fill) begin
      chk("fill_data0", fill_data0, mem_rd(base));
      chk("fill_data1", fill_data1, mem_rd(base + 32'd4));
    end
    req_valid = 1'b0; dwait = 1'b1;
    tick();
    chk("req_done_once", 32'(req_done), 32'd0);
  endtask

  // Snoop: ccinv is offered only during the lookup cycle so the sticky flag
  // must carry it to the exit. Snoop data is scrambled after the response
  // cycle so the agent must supply what it latched.
  task automatic do_snp(input logic [31:0] addr, input logic hit, input logic dirty,
                        input logic inv, input int hold, input int stall,
                        input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] base;
    logic wr, e_inv, e_clean;
    base = addr & ~32'h7;
    wr   = hit & dirty;
    ccwait = 1'b1; ccsnoopaddr = addr; ccinv = 1'b0; dwait = 1'b1;
    snp_hit = hit; snp_dirty = dirty; snp_data0 = d0; snp_data1 = d1;
    tick();
    chk("snp_addr", snp_addr, addr);
    chk_bus("snp_look", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    ccinv = inv;
    tick();
    ccinv = 1'b0;
    chk_bus("snp_resp", 1'b0, 1'b0, 1'b1, wr, 1'b0, 32'd0, 32'd0);
    chk("snp_resp_req_done", 32'(req_done), 32'd0);
    if (wr) begin
      tick();
      snp_data0 = $urandom; snp_data1 = $urandom;
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s <= stall; s++) begin
          chk_bus($sformatf("snp_wb%0d", k), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                  base + 32'(4 * k), (k == 0) ? d0 : d1);
          dwait = (s < stall);
          tick();
        end
      end
      dwait = 1'b1;
      mem[base] = d0; mem[base + 32'd4] = d1;
    end
    for (int h = 0; h <= hold; h++) begin
      chk({"snp_hold", ".cctrans"}, 32'(cctrans), 32'd1);
      chk({"snp_hold", ".dWEN"}, 32'(dWEN), 32'd0);
      chk({"snp_hold", ".pulse"}, 32'({snp_inv, snp_clean}), 32'd0);
      ccwait = (h < hold);
      tick();
    end
    e_inv   = inv & hit;
    e_clean = ~e_inv & wr;
    chk("snp_inv", 32'(snp_inv), 32'(e_inv));
    chk("snp_clean", 32'(snp_clean), 32'(e_clean));
    chk("snp_exit_cctrans", 32'(cctrans), 32'd0);
  endtask

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_op = OP_FILL_S; req_addr = '0;
    req_wdata0 = '0; req_wdata1 = '0; snp_hit = 1'b0; snp_dirty = 1'b0;
    snp_data0 = '0; snp_data1 = '0; dload = '0; dwait = 1'b1;
    ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0;
    #12;
    chk_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    chk("reset.req_done", 32'(req_done), 32'd0);
    chk("reset.fill0", fill_data0, 32'd0);
    chk("reset.snp_addr", snp_addr, 32'd0);
    chk("reset.pulses", 32'({snp_inv, snp_clean}), 32'd0);
    @(negedge CLK); nRST = 1'b1;
    tick();

    // Directed fill.
    mem[32'h1000] = 32'hAAAA0000;
    mem[32'h1004] = 32'hBBBB0000;
    do_req(OP_FILL_S, 32'h0000_1004, 32'd0, 32'd0, 0);

    // Writeback with a long stall on every word.
    do_req(OP_WB, 32'h0000_2000, 32'h11, 32'h22, 5);

    // Dirty snoop with invalidate.
    do_snp(32'h0000_3000, 1'b1, 1'b1, 1'b1, 1, 0, 32'hC0DE0000, 32'hC0DE0004);
    tick();
    chk("pulse_single", 32'({snp_inv, snp_clean}), 32'd0);

    // Dirty snoop without invalidate: downgrade.
    do_snp(32'h0000_3010, 1'b1, 1'b1, 1'b0, 0, 1, 32'h5A5A0000, 32'h5A5A0004);
    tick();

    // Snoop/request collision: snoop served first, then the held fill runs.
    req_valid = 1'b1; req_op = OP_FILL_M; req_addr = 32'h0000_5000;
    do_snp(32'h0000_5008, 1'b0, 1'b0, 1'b0, 1, 0, 32'd0, 32'd0);
    do_req(OP_FILL_M, 32'h0000_5000, 32'd0, 32'd0, 0);

    // Snoop withdrawn during lookup: no pulses even with ccinv and a hit.
    ccwait = 1'b1; ccsnoopaddr = 32'h0000_3000; snp_hit = 1'b1; snp_dirty = 1'b1;
    tick();
    ccwait = 1'b0; ccinv = 1'b1;
    tick();
    ccinv = 1'b0;
    chk("abort.cctrans", 32'(cctrans), 32'd0);
    chk("abort.pulses", 32'({snp_inv, snp_clean}), 32'd0);

    // Upgrade, then a fill cut short by reset.
    do_req(OP_UPG, 32'h0000_4000, 32'd0, 32'd0, 0);
    req_valid = 1'b1; req_op = OP_FILL_S; req_addr = 32'h0000_4010;
    dwait = 1'b0; dload = 32'h1234_5678;
    tick();
    tick();
    chk("pre_reset.dREN", 32'(dREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk_bus("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    chk("mid_reset.req_done", 32'(req_done), 32'd0);
    chk("mid_reset.fill0", fill_data0, 32'd0);
    req_valid = 1'b0; dwait = 1'b1;
    @(negedge CLK); nRST = 1'b1;
    tick();
    chk("post_reset.req_done", 32'(req_done), 32'd0);
    chk("post_reset.dREN", 32'(dREN), 32'd0);

    // Randomized mix of requests and snoops over a small address window so
    // fills observe earlier writebacks and snoop supplies.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int kind;
      a    = 32'h0000_8000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      kind = $urandom_range(0, 4);
      if (kind < 4) begin
        do_req(bus_op_t'(kind), a, $urandom, $urandom, $urandom_range(0, 2));
      end else begin
        do_snp(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom, $urandom);
        snp_hit = 1'b0; snp_dirty = 1'b0;
        tick();
        chk("rand_pulse_clear", 32'({snp_inv, snp_clean}), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
